// File: rtl/timer_unit.sv
// rtl/timer_unit.sv - programmable one-second countdown timer with expiry pulse
// Optional feature: define TIMER_REMAINING_EN to add the seconds_left output.
module timer_unit #(
  parameter int unsigned CLK_DIV    = 100000000,
  parameter logic [3:0]  T_BASE_DEF = 4'd6,
  parameter logic [3:0]  T_EXT_DEF  = 4'd3,
  parameter logic [3:0]  T_YEL_DEF  = 4'd2
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       Prog_Sync,
  input  logic [1:0] Time_Param_Sel,
  input  logic [3:0] Time_Value,
  input  logic [1:0] interval,
  input  logic       start_timer,
  output logic       expired,
  output logic       one_hz_tick
`ifdef TIMER_REMAINING_EN
  ,
  output logic [4:0] seconds_left
`endif
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [3:0]       t_base_q, t_base_d;
  logic [3:0]       t_ext_q, t_ext_d;
  logic [3:0]       t_yel_q, t_yel_d;
  logic [4:0]       dur;
  logic [3:0]       prog_val;

  // Duration of the selected interval, taken from the registers before any same-cycle write
  always_comb begin
    dur = {1'b0, t_base_q};
    case (interval)
      2'b00:   dur = {1'b0, t_base_q};
      2'b01:   dur = {1'b0, t_ext_q};
      2'b10:   dur = {1'b0, t_yel_q};
      default: dur = {t_base_q, 1'b0};
    endcase
  end

  // Next-state logic: countdown sequencing, restart override and parameter programming
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    div_d    = div_q;
    tick_d   = 1'b0;
    t_base_d = t_base_q;
    t_ext_d  = t_ext_q;
    t_yel_d  = t_yel_q;
    prog_val = Time_Value;

    case (state_q)
      IDLE: begin
        div_d = '0;
      end
      RUN: begin
        if (count_q == 5'd0) begin
          // Zero-length run finishes at once without a tick
          state_d = DONE;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          count_d = count_q - 5'd1;
          tick_d  = 1'b1;
          if (count_q == 5'd1) state_d = DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        div_d   = '0;
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase

    // A start wins over everything above: any tick this cycle is discarded
    if (start_timer) begin
      state_d = RUN;
      count_d = dur;
      div_d   = '0;
      tick_d  = 1'b0;
    end

    if (Prog_Sync) begin
      case (Time_Param_Sel)
        2'b00: begin
          prog_val = (Time_Value == 4'd0) ? T_BASE_DEF : Time_Value;
          t_base_d = prog_val;
        end
        2'b01: begin
          prog_val = (Time_Value == 4'd0) ? T_EXT_DEF : Time_Value;
          t_ext_d  = prog_val;
        end
        2'b10: begin
          prog_val = (Time_Value == 4'd0) ? T_YEL_DEF : Time_Value;
          t_yel_d  = prog_val;
        end
        default: prog_val = Time_Value;
      endcase
    end
  end

  // State register; reset overrides start and programming
  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q  <= IDLE;
      count_q  <= 5'd0;
      div_q    <= '0;
      tick_q   <= 1'b0;
      t_base_q <= T_BASE_DEF;
      t_ext_q  <= T_EXT_DEF;
      t_yel_q  <= T_YEL_DEF;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      t_base_q <= t_base_d;
      t_ext_q  <= t_ext_d;
      t_yel_q  <= t_yel_d;
    end
  end

  assign expired     = (state_q == DONE);
  assign one_hz_tick = tick_q;

`ifdef TIMER_REMAINING_EN
  assign seconds_left = (state_q == RUN) ? count_q : 5'd0;
`endif

endmodule

// File: tb/tb_timer_unit.sv
// tb/tb_timer_unit.sv - self-checking bench for timer_unit with a behavioural timing model
module tb_timer_unit;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       Reset_Sync = 1'b1;
  logic       Prog_Sync = 1'b0;
  logic [1:0] Time_Param_Sel = 2'b00;
  logic [3:0] Time_Value = 4'd0;
  logic [1:0] interval = 2'b00;
  logic       start_timer = 1'b0;
  logic       expired;
  logic       one_hz_tick;
`ifdef TIMER_REMAINING_EN
  logic [4:0] seconds_left;
`endif

  timer_unit #(
    .CLK_DIV(CD), .T_BASE_DEF(4'd6), .T_EXT_DEF(4'd3), .T_YEL_DEF(4'd2)
  ) dut (
    .clk(clk), .Reset_Sync(Reset_Sync), .Prog_Sync(Prog_Sync),
    .Time_Param_Sel(Time_Param_Sel), .Time_Value(Time_Value),
    .interval(interval), .start_timer(start_timer),
    .expired(expired), .one_hz_tick(one_hz_tick)
`ifdef TIMER_REMAINING_EN
    , .seconds_left(seconds_left)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int exp_cnt = 0, tick_cnt = 0, first_exp = -1, last_exp = -1;
  int n_checks = 0, n_fail = 0;
  int start_cyc = 0;
  int m_base = 6, m_ext = 3, m_yel = 2;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs shortly after each edge
  always @(posedge clk) begin
    #1;
    if (expired === 1'b1) begin
      exp_cnt = exp_cnt + 1;
      if (first_exp < 0) first_exp = cyc;
      last_exp = cyc;
    end
    if (one_hz_tick === 1'b1) tick_cnt = tick_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    exp_cnt = 0; tick_cnt = 0; first_exp = -1; last_exp = -1;
  endtask

  function automatic int model_dur(input int iv);
    case (iv)
      0: return m_base;
      1: return m_ext;
      2: return m_yel;
      default: return 2 * m_base;
    endcase
  endfunction

  function automatic int model_def(input int sel);
    case (sel)
      0: return 6;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_prog(input int sel, input int val);
    int v;
    v = (val == 0) ? model_def(sel) : val;
    if (sel == 0) m_base = v;
    else if (sel == 1) m_ext = v;
    else if (sel == 2) m_yel = v;
  endtask

  task automatic prog(input int sel, input int val);
    @(negedge clk);
    Prog_Sync = 1'b1; Time_Param_Sel = 2'(sel); Time_Value = 4'(val);
    @(negedge clk);
    Prog_Sync = 1'b0;
    model_prog(sel, val);
  endtask

  task automatic start(input int iv);
    @(negedge clk);
    interval = 2'(iv); start_timer = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    start_timer = 1'b0;
  endtask

  task automatic run_check(input string tag, input int iv);
    int d;
    d = model_dur(iv);
    clear_mon();
    start(iv);
    repeat (d * CD + 3) @(negedge clk);
    check({tag, "_pulses"}, exp_cnt, 1);
    check({tag, "_latency"}, last_exp - start_cyc, d * CD);
    check({tag, "_ticks"}, tick_cnt, d);
  endtask

  initial begin
    int t1, d, sel, val, iv;
    repeat (3) @(negedge clk);
    Reset_Sync = 1'b0;
    @(negedge clk);
    check("reset_expired", int'(expired), 0);
    check("reset_tick", int'(one_hz_tick), 0);
`ifdef TIMER_REMAINING_EN
    check("reset_seconds_left", int'(seconds_left), 0);
`endif

    run_check("base_run", 0);

    prog(2, 5);
    run_check("yel5_run", 2);
    prog(2, 0);
    run_check("yel_default_run", 2);

    prog(0, 15);
    run_check("double_base_run", 3);

    // Restart with tEXT at cycle 10 of a tBASE run
    clear_mon();
    start(0);
    repeat (8) @(negedge clk);
    start(1);
    repeat (m_ext * CD + 3) @(negedge clk);
    check("restart_pulses", exp_cnt, 1);
    check("restart_latency", last_exp - start_cyc, m_ext * CD);

    // Reset at cycle 9 of a run aborts it
    clear_mon();
    start(0);
    repeat (8) @(negedge clk);
    Reset_Sync = 1'b1;
    @(negedge clk);
    Reset_Sync = 1'b0;
    m_base = 6; m_ext = 3; m_yel = 2;
`ifdef TIMER_REMAINING_EN
    check("abort_seconds_left", int'(seconds_left), 0);
`endif
    repeat (80) @(negedge clk);
    check("abort_pulses", exp_cnt, 0);
    check("abort_expired", int'(expired), 0);

    // Start together with reset is ignored
    clear_mon();
    @(negedge clk);
    Reset_Sync = 1'b1; start_timer = 1'b1; interval = 2'b10;
    @(negedge clk);
    Reset_Sync = 1'b0; start_timer = 1'b0;
    repeat (20) @(negedge clk);
    check("start_in_reset_pulses", exp_cnt, 0);
    check("start_in_reset_ticks", tick_cnt, 0);

    // Start in the DONE cycle
    clear_mon();
    start(2);
    t1 = start_cyc;
    repeat (7) @(negedge clk);
    start(2);
    repeat (m_yel * CD + 3) @(negedge clk);
    check("done_restart_pulses", exp_cnt, 2);
    check("done_restart_first", first_exp - t1, m_yel * CD);
    check("done_restart_second", last_exp - start_cyc, m_yel * CD);

    // Programming in the start cycle uses the old value
    clear_mon();
    d = model_dur(1);
    @(negedge clk);
    Prog_Sync = 1'b1; Time_Param_Sel = 2'b01; Time_Value = 4'd9;
    start_timer = 1'b1; interval = 2'b01;
    @(negedge clk);
    start_cyc = cyc;
    Prog_Sync = 1'b0; start_timer = 1'b0;
    model_prog(1, 9);
    repeat (d * CD + 3) @(negedge clk);
    check("prog_with_start_latency", last_exp - start_cyc, d * CD);
    run_check("prog_next_start", 1);

    // Randomised programming and interval selection against the model
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 3));
      val = int'($urandom_range(0, 15));
      iv  = int'($urandom_range(0, 3));
      prog(sel, val);
      run_check($sformatf("rand%0d", i), iv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
